// File: rtl/serial_byte_loader_pkg.sv
// Shared definitions for the serial byte loader slice.
// Holds the FSM state encoding, the load strobe polarity and the default
// word width. Imported by the interface, the shift/count sub-block and the top.
package serial_byte_loader_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // The downstream register's Enbar input loads when low.
  localparam logic LOAD_ACTIVE = 1'b0;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PARITY  = 1'b1
  } state_e;

endpackage

// File: rtl/serial_byte_loader_if.sv
// Bus bundle between a serial source and serial_byte_loader.
// Signals:
//   SerIn, SerValid, Flush        - serial stream and abort, driven by the source
//   DataOut[WIDTH]                - last completed word
//   EnbarOut                      - active-low one-cycle load strobe
//   Busy, BitCnt[clog2(WIDTH+1)]  - partial-word status
//   ParityErr                     - parity error pulse (SERIAL_BYTE_LOADER_PARITY_EN builds)
// Modports: master = serial source, slave = the loader.
interface serial_byte_loader_if import serial_byte_loader_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             SerIn;
  logic             SerValid;
  logic             Flush;
  logic [WIDTH-1:0] DataOut;
  logic             EnbarOut;
  logic             Busy;
  logic [CW-1:0]    BitCnt;
  logic             ParityErr;

  modport master (
    output SerIn, SerValid, Flush,
    input  DataOut, EnbarOut, Busy, BitCnt, ParityErr
  );

  modport slave (
    input  SerIn, SerValid, Flush,
    output DataOut, EnbarOut, Busy, BitCnt, ParityErr
  );

endinterface

// File: rtl/serial_shift_counter.sv
// Shift register plus bit counter for serial_byte_loader (falling-edge clocked).
// Ports:
//   i_clk       - clock, state updates on the falling edge
//   i_rst_n     - synchronous active-low reset
//   i_clr       - clear shift register and counter (beats i_shift)
//   i_shift     - shift i_bit in and increment the counter
//   i_bit       - serial data bit
//   o_cnt       - bits received so far
//   o_last_c    - counter is one short of a full word
//   o_word_c    - default build: the full word including i_bit;
//                 SERIAL_BYTE_LOADER_PARITY_EN build: the held full word
//   o_par_ok_c  - (SERIAL_BYTE_LOADER_PARITY_EN only) even parity over held word + i_bit
module serial_shift_counter import serial_byte_loader_pkg::*; #(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CW       = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [CW-1:0]    o_cnt,
  output logic             o_last_c,
  output logic [WIDTH-1:0] o_word_c
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  ,
  output logic             o_par_ok_c
`endif
);

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  // The full word must be held while the parity bit is awaited.
  localparam int unsigned SW = WIDTH;
`else
  // The final bit goes straight to the output, so one bit less is stored.
  localparam int unsigned SW = WIDTH - 1;
`endif

  logic [SW-1:0] r_shreg;
  logic [SW-1:0] w_next;
  logic [CW-1:0] r_cnt;

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  if (MSB_FIRST) begin : g_msb
    assign w_next = {r_shreg[WIDTH-2:0], i_bit};
  end else begin : g_lsb
    assign w_next = {i_bit, r_shreg[WIDTH-1:1]};
  end
  assign o_word_c   = r_shreg;
  assign o_par_ok_c = ~(^r_shreg ^ i_bit);
`else
  if (MSB_FIRST) begin : g_msb
    assign o_word_c = {r_shreg, i_bit};
    assign w_next   = o_word_c[WIDTH-2:0];
  end else begin : g_lsb
    assign o_word_c = {i_bit, r_shreg};
    assign w_next   = o_word_c[WIDTH-1:1];
  end
`endif

  assign o_cnt    = r_cnt;
  assign o_last_c = (r_cnt == CW'(WIDTH - 1));

  // Shift/count register with clear priority over shift.
  always_ff @(negedge i_clk) begin
    if (!i_rst_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shreg <= w_next;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel feeder for the 8-bit load-enable register bank.
// Assembles WIDTH-bit words from a serial stream and, per completed word,
// presents it on DataOut and pulses EnbarOut low for one cycle.
// Ports:
//   ClkN - clock, all state updates on the falling edge
//   ClrN - synchronous active-low reset
//   bus  - serial_byte_loader_if.slave (SerIn, SerValid, Flush in;
//          DataOut, EnbarOut, Busy, BitCnt, ParityErr out)
// Optional feature: define SERIAL_BYTE_LOADER_PARITY_EN to require an even
// parity bit after each word; otherwise ParityErr is tied low.
module serial_byte_loader import serial_byte_loader_pkg::*; #(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                  ClkN,
  input logic                  ClrN,
  serial_byte_loader_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_enbar;
  logic             r_busy;

  logic             w_take;
  logic             w_shift;
  logic             w_clr;
  logic             w_last;
  logic [WIDTH-1:0] w_word;
  logic [CW-1:0]    w_cnt;

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  logic             r_perr;
  logic             w_par_ok;
`endif

  // A data bit is accepted only while collecting and not flushing.
  assign w_take = bus.SerValid && !bus.Flush && (r_state == ST_COLLECT);

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  // The last data bit is stored; the parity edge then clears.
  assign w_shift = w_take;
  assign w_clr   = bus.Flush || (bus.SerValid && (r_state == ST_PARITY));
`else
  // The completing bit bypasses the register and the counter wraps to 0.
  assign w_shift = w_take && !w_last;
  assign w_clr   = bus.Flush || (w_take && w_last);
`endif

  serial_shift_counter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .i_clk      (ClkN),
    .i_rst_n    (ClrN),
    .i_clr      (w_clr),
    .i_shift    (w_shift),
    .i_bit      (bus.SerIn),
    .o_cnt      (w_cnt),
    .o_last_c   (w_last),
    .o_word_c   (w_word)
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    ,
    .o_par_ok_c (w_par_ok)
`endif
  );

  // Word-complete FSM and output registers.
  always_ff @(negedge ClkN) begin
    if (!ClrN) begin
      r_state <= ST_COLLECT;
      r_data  <= '0;
      r_enbar <= ~LOAD_ACTIVE;
      r_busy  <= 1'b0;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_enbar <= ~LOAD_ACTIVE;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
      r_perr  <= 1'b0;
`endif
      if (bus.Flush) begin
        r_state <= ST_COLLECT;
        r_busy  <= 1'b0;
      end else if (bus.SerValid) begin
        case (r_state)
          ST_COLLECT: begin
            if (w_last) begin
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
              r_state <= ST_PARITY;
              r_busy  <= 1'b1;
`else
              r_data  <= w_word;
              r_enbar <= LOAD_ACTIVE;
              r_busy  <= 1'b0;
`endif
            end else begin
              r_busy <= 1'b1;
            end
          end
          ST_PARITY: begin
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
            if (w_par_ok) begin
              r_data  <= w_word;
              r_enbar <= LOAD_ACTIVE;
            end else begin
              r_perr  <= 1'b1;
            end
`endif
            r_state <= ST_COLLECT;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.DataOut  = r_data;
  assign bus.EnbarOut = r_enbar;
  assign bus.Busy     = r_busy;
  assign bus.BitCnt   = w_cnt;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  assign bus.ParityErr = r_perr;
`else
  assign bus.ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
// Directed bench for serial_byte_loader (WIDTH=8, MSB_FIRST=1).
// Inputs change 1 time unit after each falling edge; outputs are checked there.
module tb_serial_byte_loader;

  localparam int unsigned W = 8;

  logic ClkN;
  logic ClrN;

  serial_byte_loader_if #(.WIDTH(W)) bus ();

  serial_byte_loader #(
    .WIDTH     (W),
    .MSB_FIRST (1'b1)
  ) dut (
    .ClkN (ClkN),
    .ClrN (ClrN),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    ClkN = 1'b1;
    forever #5 ClkN = ~ClkN;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one falling edge, then settle just after it.
  task automatic step(input logic v, input logic b, input logic f);
    bus.SerValid = v;
    bus.SerIn    = b;
    bus.Flush    = f;
    @(negedge ClkN);
    #1;
  endtask

  logic [7:0]  word;
  logic [15:0] two;

  initial begin
    ClrN         = 1'b0;
    bus.SerIn    = 1'b0;
    bus.SerValid = 1'b0;
    bus.Flush    = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("rst_data",  32'(bus.DataOut),   32'h0);
    check("rst_enbar", 32'(bus.EnbarOut),  32'h1);
    check("rst_busy",  32'(bus.Busy),      32'h0);
    check("rst_cnt",   32'(bus.BitCnt),    32'h0);
    check("rst_perr",  32'(bus.ParityErr), 32'h0);
    ClrN = 1'b1;

`ifndef SERIAL_BYTE_LOADER_PARITY_EN
    // Single word 0xB2
    word = 8'hB2;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, word[7-i], 1'b0);
      if (i < 7) begin
        check("t1_enbar", 32'(bus.EnbarOut), 32'h1);
        check("t1_cnt",   32'(bus.BitCnt),   32'(i + 1));
        check("t1_busy",  32'(bus.Busy),     32'h1);
      end
    end
    check("t1_data",  32'(bus.DataOut),  32'hB2);
    check("t1_strb",  32'(bus.EnbarOut), 32'h0);
    check("t1_cnt0",  32'(bus.BitCnt),   32'h0);
    check("t1_busy0", 32'(bus.Busy),     32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("t1_enbar_rel", 32'(bus.EnbarOut), 32'h1);
    check("t1_hold",      32'(bus.DataOut),  32'hB2);

    // Back-to-back words 0xB2, 0x5A
    two = 16'hB25A;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, two[15-i], 1'b0);
      check("t2_enbar", 32'(bus.EnbarOut), (i == 7 || i == 15) ? 32'h0 : 32'h1);
      check("t2_cnt",   32'(bus.BitCnt),   32'((i + 1) % 8));
      if (i == 7) check("t2_data1", 32'(bus.DataOut), 32'hB2);
    end
    check("t2_data2", 32'(bus.DataOut), 32'h5A);

    // Flush mid-word, then 0xFF
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    check("t3_cnt5", 32'(bus.BitCnt), 32'h5);
    step(1'b1, 1'b1, 1'b1);
    check("t3_cnt",   32'(bus.BitCnt),   32'h0);
    check("t3_busy",  32'(bus.Busy),     32'h0);
    check("t3_enbar", 32'(bus.EnbarOut), 32'h1);
    check("t3_data",  32'(bus.DataOut),  32'h5A);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
    check("t3_ff",      32'(bus.DataOut),  32'hFF);
    check("t3_ff_strb", 32'(bus.EnbarOut), 32'h0);

    // Flush on the completing edge discards the word
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("t3b_enbar", 32'(bus.EnbarOut), 32'h1);
    check("t3b_data",  32'(bus.DataOut),  32'hFF);
    check("t3b_cnt",   32'(bus.BitCnt),   32'h0);

    // Gapped stream 0x3C
    word = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, word[7-i], 1'b0);
      if (i < 7) begin
        check("t4_data_old", 32'(bus.DataOut),  32'hFF);
        check("t4_enbar",    32'(bus.EnbarOut), 32'h1);
        for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b0);
        check("t4_cnt_idle", 32'(bus.BitCnt), 32'(i + 1));
      end
    end
    check("t4_data", 32'(bus.DataOut),  32'h3C);
    check("t4_strb", 32'(bus.EnbarOut), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("t4_rel", 32'(bus.EnbarOut), 32'h1);

    // Reset mid-word
    word = 8'hA5;
    for (int i = 0; i < 4; i++) step(1'b1, word[7-i], 1'b0);
    check("t5_cnt4", 32'(bus.BitCnt), 32'h4);
    ClrN = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    ClrN = 1'b1;
    check("t5_data",  32'(bus.DataOut),  32'h0);
    check("t5_enbar", 32'(bus.EnbarOut), 32'h1);
    check("t5_busy",  32'(bus.Busy),     32'h0);
    check("t5_cnt",   32'(bus.BitCnt),   32'h0);

    // Reset pulse between falling edges is ignored
    for (int i = 0; i < 3; i++) step(1'b1, word[7-i], 1'b0);
    ClrN = 1'b0;
    #3;
    ClrN = 1'b1;
    for (int i = 3; i < 8; i++) begin
      step(1'b1, word[7-i], 1'b0);
      if (i == 3) check("t5_glitch_cnt", 32'(bus.BitCnt), 32'h4);
    end
    check("t5_word", 32'(bus.DataOut),  32'hA5);
    check("t5_strb", 32'(bus.EnbarOut), 32'h0);
`else
    // 0xB2 with correct parity 0
    word = 8'hB2;
    for (int i = 0; i < 8; i++) step(1'b1, word[7-i], 1'b0);
    check("p_wait_busy",  32'(bus.Busy),     32'h1);
    check("p_wait_cnt",   32'(bus.BitCnt),   32'h8);
    check("p_wait_enbar", 32'(bus.EnbarOut), 32'h1);
    check("p_wait_data",  32'(bus.DataOut),  32'h0);
    step(1'b1, 1'b0, 1'b0);
    check("p_ok_data",  32'(bus.DataOut),   32'hB2);
    check("p_ok_strb",  32'(bus.EnbarOut),  32'h0);
    check("p_ok_perr",  32'(bus.ParityErr), 32'h0);
    check("p_ok_cnt",   32'(bus.BitCnt),    32'h0);
    check("p_ok_busy",  32'(bus.Busy),      32'h0);

    // 0x5A with wrong parity 1
    word = 8'h5A;
    for (int i = 0; i < 8; i++) step(1'b1, word[7-i], 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("p_bad_perr",  32'(bus.ParityErr), 32'h1);
    check("p_bad_enbar", 32'(bus.EnbarOut),  32'h1);
    check("p_bad_data",  32'(bus.DataOut),   32'hB2);
    check("p_bad_cnt",   32'(bus.BitCnt),    32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("p_perr_rel", 32'(bus.ParityErr), 32'h0);

    // Flush while waiting for parity
    for (int i = 0; i < 8; i++) step(1'b1, word[7-i], 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("p_fl_busy",  32'(bus.Busy),     32'h0);
    check("p_fl_enbar", 32'(bus.EnbarOut), 32'h1);
    check("p_fl_data",  32'(bus.DataOut),  32'hB2);
    for (int i = 0; i < 8; i++) step(1'b1, word[7-i], 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("p_5a_data", 32'(bus.DataOut),  32'h5A);
    check("p_5a_strb", 32'(bus.EnbarOut), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
